// File: rtl/rggen_register_access_master.sv
// Initiator end of the rggen register bus.
// Issues one register access per command and returns its status/data.
module rggen_register_access_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_direction,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
    input  logic [DATA_WIDTH-1:0]     cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strobe,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [DATA_WIDTH-1:0]     rsp_read_data,
    output logic                      reg_valid,
    output logic                      reg_direction,
    output logic [ADDRESS_WIDTH-1:0]  reg_address,
    output logic [DATA_WIDTH-1:0]     reg_write_data,
    output logic [DATA_WIDTH/8-1:0]   reg_strobe,
    input  logic                      reg_ready,
    input  logic [1:0]                reg_status,
    input  logic [DATA_WIDTH-1:0]     reg_read_data,
    output logic                      timeout_pulse,
    output logic                      busy
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic          TO_EN    = (TIMEOUT_CYCLES > 0);

    localparam logic       RGGEN_WRITE       = 1'b1;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    state_e                   state_q, state_d;
    logic                     dir_q, dir_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]            strb_q, strb_d;
    logic [1:0]               status_q, status_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     pulse_q, pulse_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     timeout_hit;

    // Abort when the last allowed access cycle passes without reg_ready.
    assign timeout_hit = TO_EN && (count_q == CNT_LAST);

    // Next-state and datapath updates for the access sequencer.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        pulse_d  = 1'b0;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_direction;
                    addr_d  = cmd_address;
                    count_d = '0;
                    state_d = ACCESS;
                    if (cmd_direction == RGGEN_WRITE) begin
                        wdata_d = cmd_write_data;
                        strb_d  = cmd_strobe;
                    end else begin
                        wdata_d = '0;
                        strb_d  = '1;
                    end
                end
            end
            ACCESS: begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (reg_ready) begin
                    status_d = reg_status;
                    state_d  = RESPOND;
                    if (dir_q == RGGEN_WRITE) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = reg_read_data;
                    end
                end else if (timeout_hit) begin
                    status_d = RGGEN_SLAVE_ERROR;
                    rdata_d  = '0;
                    pulse_d  = 1'b1;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            status_q <= 2'b00;
            rdata_q  <= '0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign reg_valid      = (state_q == ACCESS);
    assign rsp_valid      = (state_q == RESPOND);
    assign busy           = (state_q != IDLE);
    assign reg_direction  = dir_q;
    assign reg_address    = addr_q;
    assign reg_write_data = wdata_q;
    assign reg_strobe     = strb_q;
    assign rsp_status     = status_q;
    assign rsp_read_data  = rdata_q;
    assign timeout_pulse  = pulse_q;

endmodule

// File: tb/tb_rggen_register_access_master.sv
// Bench for rggen_register_access_master.
// Directed and random transactions against a transaction-level model.
module tb_rggen_register_access_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_direction;
    logic [15:0] cmd_address;
    logic [31:0] cmd_write_data;
    logic [3:0]  cmd_strobe;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_read_data;
    logic        reg_valid;
    logic        reg_direction;
    logic [15:0] reg_address;
    logic [31:0] reg_write_data;
    logic [3:0]  reg_strobe;
    logic        reg_ready;
    logic [1:0]  reg_status;
    logic [31:0] reg_read_data;
    logic        timeout_pulse;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rggen_register_access_master #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_direction  (cmd_direction),
        .cmd_address    (cmd_address),
        .cmd_write_data (cmd_write_data),
        .cmd_strobe     (cmd_strobe),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_read_data  (rsp_read_data),
        .reg_valid      (reg_valid),
        .reg_direction  (reg_direction),
        .reg_address    (reg_address),
        .reg_write_data (reg_write_data),
        .reg_strobe     (reg_strobe),
        .reg_ready      (reg_ready),
        .reg_status     (reg_status),
        .reg_read_data  (reg_read_data),
        .timeout_pulse  (timeout_pulse),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // One command through the DUT; the expected bus behaviour comes
    // from the rules: ready_at is the access cycle the responder
    // completes in (0 = never), a timeout ends the access after T cycles.
    task automatic do_txn(input logic        dir,
                          input logic [15:0] addr,
                          input logic [31:0] wd,
                          input logic [3:0]  st,
                          input int          ready_at,
                          input logic [1:0]  rstat,
                          input logic [31:0] rdata,
                          input int          rsp_wait,
                          input bit          hold_valid,
                          output int         acc_cyc);
        bit          to;
        int          n_acc;
        int          busy_n;
        logic [31:0] e_wd;
        logic [3:0]  e_st;
        logic [1:0]  e_status;
        logic [31:0] e_data;
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) tick();
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        cmd_valid      = 1'b1;
        cmd_direction  = dir;
        cmd_address    = addr;
        cmd_write_data = wd;
        cmd_strobe     = st;
        reg_ready      = 1'b0;
        tick();
        acc_cyc = cyc;
        if (!hold_valid) cmd_valid = 1'b0;
        e_wd     = dir ? wd : 32'h0;
        e_st     = dir ? st : 4'hf;
        to       = !(ready_at != 0 && (T == 0 || ready_at <= T));
        n_acc    = to ? T : ready_at;
        e_status = to ? 2'b10 : rstat;
        e_data   = (to || dir) ? 32'h0 : rdata;
        busy_n   = 0;
        for (int k = 1; k <= n_acc; k++) begin
            check("reg_valid", reg_valid, 1);
            check("reg_direction", reg_direction, dir);
            check("reg_address", reg_address, addr);
            check("reg_write_data", reg_write_data, e_wd);
            check("reg_strobe", reg_strobe, e_st);
            check("cmd_ready_access", cmd_ready, 0);
            check("rsp_valid_access", rsp_valid, 0);
            check("pulse_access", timeout_pulse, 0);
            busy_n += int'(busy);
            if (k == ready_at) begin
                reg_ready     = 1'b1;
                reg_status    = rstat;
                reg_read_data = rdata;
            end else begin
                reg_ready     = 1'b0;
                reg_status    = 2'($urandom);
                reg_read_data = $urandom;
            end
            tick();
        end
        for (int w = 0; w <= rsp_wait; w++) begin
            check("reg_valid_respond", reg_valid, 0);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_status", rsp_status, e_status);
            check("rsp_read_data", rsp_read_data, e_data);
            check("timeout_pulse", timeout_pulse,
                  (w == 0) ? to : 1'b0);
            check("cmd_ready_respond", cmd_ready, 0);
            busy_n += int'(busy);
            rsp_ready     = (w == rsp_wait);
            reg_ready     = (w != rsp_wait);
            reg_status    = ~e_status;
            reg_read_data = $urandom;
            tick();
        end
        rsp_ready = 1'b0;
        reg_ready = 1'b0;
        check("rsp_valid_done", rsp_valid, 0);
        check("cmd_ready_done", cmd_ready, 1);
        check("pulse_done", timeout_pulse, 0);
        check("busy_cycles", busy_n, n_acc + rsp_wait + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2;
        logic dir;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_direction  = 1'b0;
        cmd_address    = '0;
        cmd_write_data = '0;
        cmd_strobe     = '0;
        rsp_ready      = 1'b0;
        reg_ready      = 1'b0;
        reg_status     = 2'b00;
        reg_read_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_reg_valid", reg_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_data", rsp_read_data, 0);
        check("rst_reg_address", reg_address, 0);
        check("rst_reg_wdata", reg_write_data, 0);
        check("rst_reg_strobe", reg_strobe, 0);
        check("rst_reg_dir", reg_direction, 0);
        check("rst_pulse", timeout_pulse, 0);
        check("rst_busy", busy, 0);

        reg_ready     = 1'b1;
        reg_status    = 2'b11;
        reg_read_data = 32'hffff_ffff;
        tick();
        tick();
        reg_ready = 1'b0;
        check("idle_ready_ignored", rsp_valid, 0);
        check("idle_ready_busy", busy, 0);

        do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 2, 2'b00,
               32'hDEADBEEF, 1, 1'b0, c0);
        do_txn(1'b1, 16'h0020, 32'h12345678, 4'b0101, 1, 2'b00,
               32'hCAFEF00D, 0, 1'b0, c0);
        do_txn(1'b0, 16'h0030, 32'h0, 4'h0, 0, 2'b00,
               32'h11111111, 0, 1'b0, c0);
        do_txn(1'b0, 16'h0034, 32'h0, 4'h0, 4, 2'b01,
               32'h2222_3333, 0, 1'b0, c0);
        do_txn(1'b1, 16'h0038, 32'hAAAA5555, 4'hF, 0, 2'b00,
               32'h0, 1, 1'b0, c0);
        do_txn(1'b1, 16'h0040, 32'h0BAD0BAD, 4'h0, 1, 2'b00,
               32'h0, 0, 1'b0, c0);

        do_txn(1'b1, 16'h0044, 32'h55AA55AA, 4'h3, 1, 2'b11,
               32'h77777777, 5, 1'b1, c0);
        cmd_valid = 1'b0;

        do_txn(1'b1, 16'h0100, 32'h00000001, 4'h1, 1, 2'b00,
               32'h0, 0, 1'b1, c0);
        do_txn(1'b0, 16'h0104, 32'h0, 4'h0, 1, 2'b01,
               32'h00000002, 0, 1'b1, c1);
        do_txn(1'b1, 16'h0108, 32'h00000003, 4'hC, 1, 2'b00,
               32'h0, 0, 1'b1, c2);
        cmd_valid = 1'b0;
        check("b2b_gap_1", c1 - c0, 3);
        check("b2b_gap_2", c2 - c1, 3);

        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) tick();
        cmd_valid      = 1'b1;
        cmd_direction  = 1'b1;
        cmd_address    = 16'h0200;
        cmd_write_data = 32'h13579BDF;
        cmd_strobe     = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("rst_mid_reg_valid", reg_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_reg_valid0", reg_valid, 0);
        check("rst_mid_rsp_valid0", rsp_valid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_address", reg_address, 0);
        check("rst_mid_pulse", timeout_pulse, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        tick();
        check("rst_mid_no_rsp", rsp_valid, 0);
        do_txn(1'b0, 16'h0204, 32'h0, 4'h0, 2, 2'b00,
               32'h89ABCDEF, 0, 1'b0, c0);

        for (int n = 0; n < 24; n++) begin
            dir = 1'($urandom);
            do_txn(dir, 16'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 6)), 2'($urandom),
                   $urandom, int'($urandom_range(0, 2)),
                   1'b0, c0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
